// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide execute unit.
// Takes two register-file operands plus a destination index and returns the
// result with that index for write-back. Shift-add multiply (LSB first) and
// restoring divide (MSB first), one step per clock.
// Optional feature: define MULDIV_SIGNED_EN to honour sgn (two's complement
// operands via magnitude + final negation). Undefined: all ops unsigned.
//
// Handshake: start is sampled only while idle (busy=0). An accepted start
// raises busy on the same edge; busy stays high through RUN and the DONE
// cycle. done is a one-cycle pulse marking result/dest_out/div_zero valid;
// those three hold until the next operation completes. start while busy is
// dropped, not queued.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            sgn,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      dest_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest_out,
  output logic            div_zero,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;
  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [4:0]       cnt;
  logic [4:0]       dest_q;
  logic [63:0]      acc;       // mul: {partial product}; div: {remainder, quotient}
  logic [31:0]      sh_q;      // mul: multiplier; div: dividend (shifted out)
  logic [31:0]      opd_q;     // mul: multiplicand; div: divisor
  logic [31:0]      opa_q;     // raw operand A, returned by REMU on divide-by-zero
  logic             dz_q;

  logic [31:0]      mag_a;
  logic [31:0]      mag_b;
  logic             is_div;
  logic [32:0]      mul_sum;
  logic [32:0]      div_sh;
  logic [32:0]      div_sub;
  logic             div_ge;
  logic [63:0]      acc_next;
  logic [31:0]      sh_next;
  logic [63:0]      prod;
  logic [31:0]      quo;
  logic [31:0]      rem;
  logic [31:0]      res_fin;

`ifdef MULDIV_SIGNED_EN
  logic             neg_q;
  logic             neg_n;
  logic             sa;
  logic             sb;

  // Operand magnitudes and result sign for a signed request
  always_comb begin
    sa    = sgn & opa[31];
    sb    = sgn & opb[31];
    mag_a = sa ? -opa : opa;
    mag_b = sb ? -opb : opb;
    neg_n = (op == OP_REMU) ? sa : (sa ^ sb);
  end
`else
  logic             unused_sgn;
  assign unused_sgn = sgn;

  // Unsigned-only build: operands pass straight through
  always_comb begin
    mag_a = opa;
    mag_b = opb;
  end
`endif

  // One shift-add or restoring-divide step from the current registers
  always_comb begin
    is_div   = op_q[1];
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (sh_q[0] ? opd_q : 32'd0)};
    div_sh   = {acc[63:32], sh_q[31]};
    div_sub  = div_sh - {1'b0, opd_q};
    div_ge   = (div_sh >= {1'b0, opd_q});
    if (is_div) begin
      acc_next = {(div_ge ? div_sub[31:0] : div_sh[31:0]), acc[30:0], div_ge};
      sh_next  = {sh_q[30:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
      sh_next  = {1'b0, sh_q[31:1]};
    end
  end

  // Final result selection, including sign fix-up and divide-by-zero values
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod = neg_q ? -acc_next : acc_next;
    quo  = neg_q ? -acc_next[31:0] : acc_next[31:0];
    rem  = neg_q ? -acc_next[63:32] : acc_next[63:32];
`else
    prod = acc_next;
    quo  = acc_next[31:0];
    rem  = acc_next[63:32];
`endif
    res_fin = 32'd0;
    if (dz_q) begin
      res_fin = (op_q == OP_REMU) ? opa_q : 32'hFFFF_FFFF;
    end else begin
      case (op_q)
        OP_MUL:   res_fin = prod[31:0];
        OP_MULHU: res_fin = prod[63:32];
        OP_DIVU:  res_fin = quo;
        default:  res_fin = rem;
      endcase
    end
  end

  // Control FSM and datapath registers; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= 2'b00;
      cnt      <= 5'd0;
      dest_q   <= 5'd0;
      acc      <= 64'd0;
      sh_q     <= 32'd0;
      opd_q    <= 32'd0;
      opa_q    <= 32'd0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'd0;
      dest_out <= 5'd0;
      div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            opa_q  <= opa;
            dest_q <= dest_in;
            acc    <= 64'd0;
            busy   <= 1'b1;
            state  <= S_RUN;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= neg_n;
`endif
            if (op[1]) begin
              sh_q  <= mag_a;
              opd_q <= mag_b;
            end else begin
              sh_q  <= mag_b;
              opd_q <= mag_a;
            end
            // Divide-by-zero skips the iterations: preloading the last count
            // makes the very next edge load the result and enter DONE.
            if (op[1] && (opb == 32'd0)) begin
              dz_q <= 1'b1;
              cnt  <= LAST_CNT;
            end else begin
              dz_q <= 1'b0;
              cnt  <= 5'd0;
            end
          end
        end
        S_RUN: begin
          acc  <= acc_next;
          sh_q <= sh_next;
          cnt  <= cnt + 5'd1;
          if (cnt == LAST_CNT) begin
            result   <= res_fin;
            dest_out <= dest_q;
            div_zero <= dz_q;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
